dmem_arbiter: RTL

- Shares the single data-memory port between the core MEM stage (port CORE) and an auxiliary master such as a debug module or DMA (port AUX).
- Converts both requesters to an OBI-style req/gnt/rvalid bus with at most one outstanding transaction.
- Generates the MEM-stage stall while a core access is pending.
- Sits between the MEM stage dmem_* interface and the memory/interconnect.

---
 rtl/dmem_arbiter_pkg.sv | 30 +++
 rtl/dmem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
//   Shared types for the data-memory arbiter: port ownership, arbiter FSM
//   state, and a bundle of the request attributes that are steered onto the
//   memory bus.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    // Which requester owns the current/next memory transaction.
    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_AUX  = 1'b1
    } dmem_owner_t;

    // ARB_IDLE: nothing outstanding, a request may issue.
    // ARB_RESP: one transaction outstanding, waiting for bus_rvalid_i.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } dmem_arb_state_t;

    // Request attributes carried from a requester to the memory bus.
    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  ben;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single data-memory port between the core MEM stage (CORE) and
//   an auxiliary master such as debug or DMA (AUX). Presents an OBI-style
//   req/gnt/rvalid bus with at most one outstanding transaction, and stalls
//   the MEM stage while a core access is pending.
//
// Ports
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   core_req_i ... wdata_i    MEM-stage request, held until core_rvalid_o
//   core_rdata_o/rvalid_o     core response (rdata is 0 when not valid)
//   core_stall_o              stall for MEM and earlier stages
//   aux_req_i ... wdata_i     AUX request, held until aux_gnt_o
//   aux_gnt_o                 AUX request accepted this cycle
//   aux_rvalid_o/rdata_o      AUX response (rdata is 0 when not valid)
//   bus_req_o ... wdata_o     memory request towards the interconnect
//   bus_gnt_i                 memory accepted the request
//   bus_rvalid_i/rdata_i      memory response, one per granted request
//
// Parameters
//   MAX_WAIT  consecutive core grants tolerated while AUX waits (1..15)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        core_req_i,
    input  logic [31:0] core_addr_i,
    input  logic        core_wen_i,
    input  logic [3:0]  core_ben_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] core_rdata_o,
    output logic        core_rvalid_o,
    output logic        core_stall_o,

    input  logic        aux_req_i,
    input  logic [31:0] aux_addr_i,
    input  logic        aux_wen_i,
    input  logic [3:0]  aux_ben_i,
    input  logic [31:0] aux_wdata_i,
    output logic        aux_gnt_o,
    output logic        aux_rvalid_o,
    output logic [31:0] aux_rdata_o,

    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    output logic        bus_wen_o,
    output logic [3:0]  bus_ben_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int unsigned      CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_WAIT);

    dmem_arb_state_t  state_q, state_d;
    logic             lock_valid_q, lock_valid_d;
    dmem_owner_t      lock_owner_q, lock_owner_d;
    dmem_owner_t      resp_owner_q, resp_owner_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    dmem_req_t   core_bus, aux_bus, sel_bus;
    dmem_owner_t sel_owner;
    logic        sel_req;
    logic        grant;
    logic        resp_done;
    logic        core_rvalid, aux_rvalid;

    assign core_bus = '{addr: core_addr_i, wen: core_wen_i, ben: core_ben_i, wdata: core_wdata_i};
    assign aux_bus  = '{addr: aux_addr_i,  wen: aux_wen_i,  ben: aux_ben_i,  wdata: aux_wdata_i};

    // Owner selection. A pending (locked) request keeps the bus until it is
    // granted so the attributes seen by the memory never change mid-handshake.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel_owner = OWNER_CORE;
        if (lock_valid_q) begin
            sel_owner = lock_owner_q;
        end else if (aux_req_i && !core_req_i) begin
            sel_owner = OWNER_AUX;
        end else if (aux_req_i && core_req_i && (starve_cnt_q == STARVE_MAX)) begin
            sel_owner = OWNER_AUX;
        end
    end

    assign sel_req   = (sel_owner == OWNER_AUX) ? aux_req_i : core_req_i;
    assign sel_bus   = (sel_owner == OWNER_AUX) ? aux_bus   : core_bus;

    assign bus_req_o   = (state_q == ARB_IDLE) && sel_req;
    assign bus_addr_o  = sel_bus.addr;
    assign bus_wen_o   = sel_bus.wen;
    assign bus_ben_o   = sel_bus.ben;
    assign bus_wdata_o = sel_bus.wdata;

    assign grant     = bus_req_o && bus_gnt_i;
    assign resp_done = (state_q == ARB_RESP) && bus_rvalid_i;

    // Next-state logic for the FSM, lock and starvation counter.
    always_comb begin
        state_d      = state_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        resp_owner_d = resp_owner_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    state_d      = ARB_RESP;
                    resp_owner_d = sel_owner;
                    lock_valid_d = 1'b0;
                end else if (bus_req_o) begin
                    lock_valid_d = 1'b1;
                    lock_owner_d = sel_owner;
                end
            end
            ARB_RESP: begin
                // The response cycle never issues, so each access takes at
                // least two cycles.
                if (bus_rvalid_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // The counter only measures how long AUX has been kept waiting, so it
        // collapses as soon as AUX stops asking or gets served.
        if (!aux_req_i) begin
            starve_cnt_d = '0;
        end else if (grant) begin
            if (sel_owner == OWNER_AUX) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != STARVE_MAX) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q      <= ARB_IDLE;
            lock_valid_q <= 1'b0;
            lock_owner_q <= OWNER_CORE;
            resp_owner_q <= OWNER_CORE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            resp_owner_q <= resp_owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Responses are steered to the recorded owner; the idle port sees zero
    // read data. A stray bus_rvalid_i in ARB_IDLE reaches neither port.
    always_comb begin
        core_rvalid  = 1'b0;
        aux_rvalid   = 1'b0;
        core_rdata_o = '0;
        aux_rdata_o  = '0;
        if (resp_done) begin
            if (resp_owner_q == OWNER_AUX) begin
                aux_rvalid  = 1'b1;
                aux_rdata_o = bus_rdata_i;
            end else begin
                core_rvalid  = 1'b1;
                core_rdata_o = bus_rdata_i;
            end
        end
    end

    assign core_rvalid_o = core_rvalid;
    assign aux_rvalid_o  = aux_rvalid;
    assign aux_gnt_o     = grant && (sel_owner == OWNER_AUX);

    // Drops in the rvalid cycle so the MEM stage consumes rdata and advances;
    // stores stall until their response as well.
    assign core_stall_o  = core_req_i && !core_rvalid;

    // Protocol monitors.
    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            if (state_q == ARB_IDLE) begin
                assert (!bus_rvalid_i)
                else $warning("dmem_arbiter: bus_rvalid_i with no outstanding transaction, ignored");
            end
            if ((state_q == ARB_IDLE) && lock_valid_q) begin
                assert (sel_req)
                else $error("dmem_arbiter: locked requester dropped req before gnt");
            end
        end
    end

endmodule
